// File: rtl/stopwatch_lap_recorder.sv
// rtl/stopwatch_lap_recorder.sv - lap capture FIFO with drop counting.
// Define STOPWATCH_LAP_DELTA_EN to store lap deltas (mod MAX+1) instead of raw counts.
module stopwatch_lap_recorder #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         count_in,
  input  logic                          lap,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [7:0]                    out_seq,
  output logic [$clog2(DEPTH):0]        level,
  output logic [7:0]                    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [7:0]            mem_seq  [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [LW-1:0]         level_q;
  logic [7:0]            lap_seq;
  logic [7:0]            drop_q;

  logic                  lap_ev;
  logic                  pop;
  logic                  full;
  logic                  push;
  logic                  drop;
  logic [DATA_WIDTH-1:0] lap_value;

  assign lap_ev = lap & ~clear;
  assign pop    = out_valid & out_ready & ~clear;
  assign full   = (level_q == FULL_LEVEL);
  assign push   = lap_ev & (~full | pop);
  assign drop   = lap_ev & full & ~pop;

`ifdef STOPWATCH_LAP_DELTA_EN
  localparam int DW1 = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH:0] MAX_P1 = DW1'(MAX + 1);

  logic [DATA_WIDTH-1:0] prev_lap;
  logic [DATA_WIDTH:0]   wide_delta;
  logic                  delta_msb_unused;

  // One extra bit keeps count_in + MAX + 1 from wrapping before the subtract.
  always_comb begin
    wide_delta = '0;
    if (count_in >= prev_lap)
      wide_delta = {1'b0, count_in} - {1'b0, prev_lap};
    else
      wide_delta = {1'b0, count_in} + MAX_P1 - {1'b0, prev_lap};
  end

  assign lap_value        = wide_delta[DATA_WIDTH-1:0];
  assign delta_msb_unused = wide_delta[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (reset || clear)
      prev_lap <= '0;
    else if (lap_ev)
      prev_lap <= count_in;
  end
`else
  assign lap_value = count_in;
`endif

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_data[wr_ptr] <= lap_value;
      mem_seq[wr_ptr]  <= lap_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      lap_seq <= '0;
      drop_q  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (lap_ev)
        lap_seq <= lap_seq + 8'd1;
      if (drop && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Head is shown only while valid so the empty/reset state reads as zero.
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_seq   = out_valid ? mem_seq[rd_ptr]  : 8'd0;
  assign level     = level_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stopwatch_lap_recorder.sv
// tb/tb_stopwatch_lap_recorder.sv - directed bench for stopwatch_lap_recorder.
module tb_stopwatch_lap_recorder;

`ifdef STOPWATCH_LAP_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] count_in = '0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_seq;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_lap_recorder #(.DATA_WIDTH(16), .MAX(99), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .lap(lap), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_seq(out_seq), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lap_at(input logic [15:0] v);
    lap = 1'b1; count_in = v; tick(); lap = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_checks++; if (out_data !== 16'd0 || out_seq !== 8'd0) begin n_fail++; $display("FAIL reset_head got %0d/%0d want 0/0", out_data, out_seq); end
  endtask

  task automatic test_first_lap();
    reset = 1'b0; lap_at(16'd10);
    n_checks++; if (out_valid !== 1'b1 || level !== 3'd1) begin n_fail++; $display("FAIL first_lap_valid got %0b/%0d want 1/1", out_valid, level); end
    n_checks++; if (out_data !== 16'd10 || out_seq !== 8'd0) begin n_fail++; $display("FAIL first_lap_head got %0d/%0d want 10/0", out_data, out_seq); end
    pop_one();
    n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL first_lap_pop got %0b/%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_delta();
    do_clear();
    lap_at(16'd30); lap_at(16'd75);
    n_checks++; if (out_data !== 16'd30 || out_seq !== 8'd0 || level !== 3'd2) begin n_fail++; $display("FAIL delta_first got %0d/%0d/%0d want 30/0/2", out_data, out_seq, level); end
    tick();
    n_checks++; if (out_data !== 16'd30 || out_seq !== 8'd0) begin n_fail++; $display("FAIL delta_hold got %0d/%0d want 30/0", out_data, out_seq); end
    pop_one();
    n_checks++; if (out_data !== (DELTA ? 16'd45 : 16'd75) || out_seq !== 8'd1) begin n_fail++; $display("FAIL delta_second got %0d/%0d want %0d/1", out_data, out_seq, DELTA ? 45 : 75); end
  endtask

  task automatic test_wrap();
    do_clear();
    lap_at(16'd90); lap_at(16'd5);
    pop_one();
    n_checks++; if (out_data !== (DELTA ? 16'd15 : 16'd5) || out_seq !== 8'd1) begin n_fail++; $display("FAIL wrap got %0d/%0d want %0d/1", out_data, out_seq, DELTA ? 15 : 5); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 1; i <= 5; i++) lap_at(16'(i * 10));
    n_checks++; if (level !== 3'd4 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL overflow_level got %0d/%0d want 4/1", level, drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data !== (DELTA ? 16'd10 : 16'((i + 1) * 10)) || out_seq !== 8'(i)) begin
        n_fail++; $display("FAIL overflow_drain%0d got %0d/%0d want %0d/%0d", i, out_data, out_seq, DELTA ? 10 : (i + 1) * 10, i);
      end
      pop_one();
    end
    n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL overflow_empty got %0b/%0d want 0/0", out_valid, level); end
    lap_at(16'd65);
    n_checks++; if (out_data !== (DELTA ? 16'd15 : 16'd65) || out_seq !== 8'd5) begin n_fail++; $display("FAIL overflow_next got %0d/%0d want %0d/5", out_data, out_seq, DELTA ? 15 : 65); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 1; i <= 4; i++) lap_at(16'(i * 10));
    lap = 1'b1; count_in = 16'd60; out_ready = 1'b1; tick(); lap = 1'b0; out_ready = 1'b0;
    n_checks++; if (level !== 3'd4 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_level got %0d/%0d want 4/0", level, drop_cnt); end
    n_checks++; if (out_data !== (DELTA ? 16'd10 : 16'd20) || out_seq !== 8'd1) begin n_fail++; $display("FAIL b2b_head got %0d/%0d want %0d/1", out_data, out_seq, DELTA ? 10 : 20); end
    pop_one(); pop_one(); pop_one();
    n_checks++; if (out_data !== (DELTA ? 16'd20 : 16'd60) || out_seq !== 8'd4 || level !== 3'd1) begin n_fail++; $display("FAIL b2b_tail got %0d/%0d/%0d want %0d/4/1", out_data, out_seq, level, DELTA ? 20 : 60); end
  endtask

  task automatic test_clear_lap();
    do_clear();
    for (int i = 1; i <= 5; i++) lap_at(16'(i * 10));
    pop_one();
    n_checks++; if (level !== 3'd3 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL clear_pre got %0d/%0d want 3/1", level, drop_cnt); end
    clear = 1'b1; lap = 1'b1; count_in = 16'd99; out_ready = 1'b1; tick();
    clear = 1'b0; lap = 1'b0; out_ready = 1'b0;
    n_checks++; if (level !== 3'd0 || out_valid !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL clear_state got %0d/%0b/%0d want 0/0/0", level, out_valid, drop_cnt); end
    pop_one();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL empty_ready got %0d want 0", level); end
    lap_at(16'd40);
    n_checks++; if (out_data !== 16'd40 || out_seq !== 8'd0 || level !== 3'd1) begin n_fail++; $display("FAIL clear_next got %0d/%0d/%0d want 40/0/1", out_data, out_seq, level); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    lap_at(16'd5); lap_at(16'd8);
    reset = 1'b1; lap = 1'b1; count_in = 16'd9; tick(); lap = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 16'd0) begin n_fail++; $display("FAIL reset_mid got %0b/%0d/%0d want 0/0/0", out_valid, level, out_data); end
    reset = 1'b0; lap_at(16'd7);
    n_checks++; if (out_data !== 16'd7 || out_seq !== 8'd0 || level !== 3'd1) begin n_fail++; $display("FAIL reset_resume got %0d/%0d/%0d want 7/0/1", out_data, out_seq, level); end
  endtask

  initial begin
    test_reset();
    test_first_lap();
    test_delta();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_clear_lap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
